// File: rtl/ram_pkg.sv
// ram_pkg: shared types, constants and helpers for the banked single-port RAM.
//
// Contents:
//   lane_cnt / lane_bits : byte-lane count and lane-select bit count for a bus width
//   ram_req_t            : request bundle {wr, addr, wdata, mask}
//   ram_rsp_t            : response bundle {rdata, err}
//   sat_inc              : 32-bit saturating increment used by the statistics counters
//
// The bundle types are sized for the widest supported bus. Instances of
// narrower configurations use the low bits and leave the rest at zero.
package ram_pkg;

  localparam int RAM_MAX_DW = 512;
  localparam int RAM_MAX_AW = 64;

  function automatic int lane_cnt(input int dw);
    return dw / 8;
  endfunction

  function automatic int lane_bits(input int dw);
    return (dw / 8 <= 1) ? 0 : $clog2(dw / 8);
  endfunction

  typedef struct packed {
    logic                    wr;
    logic [RAM_MAX_AW-1:0]   addr;
    logic [RAM_MAX_DW-1:0]   wdata;
    logic [RAM_MAX_DW/8-1:0] mask;
  } ram_req_t;

  typedef struct packed {
    logic [RAM_MAX_DW-1:0] rdata;
    logic                  err;
  } ram_rsp_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ram_lane.sv
// ram_lane: one byte lane of the banked RAM, 8 bits x 2**DEPTH_BITS.
//
// Ports:
//   clk_i   : clock
//   we_i    : write enable, writes wdata_i at addr_i on the clock edge
//   re_i    : read enable, loads the word at addr_i into the read register
//   addr_i  : word index
//   wdata_i : write byte
//   rdata_o : registered read byte; holds its value while re_i is low
//
// The array and the read register carry no reset so the storage maps onto
// block RAM; the parent gates we_i/re_i during reset.
module ram_lane
  import ram_pkg::*;
#(
  parameter int DEPTH_BITS = 12
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [DEPTH_BITS-1:0] addr_i,
  input  logic [7:0]            wdata_i,
  output logic [7:0]            rdata_o
);

  logic [7:0] mem_q [2**DEPTH_BITS];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_banked_sp.sv
// ram_banked_sp: parametrised byte-lane-banked single-port data RAM with
// valid/ready request and response channels and a 1-cycle registered read.
//
// Ports:
//   i_sys_clk, i_sys_rst_n : clock, synchronous active-low reset
//   i_req_valid/o_req_ready: request handshake
//   i_req_wr, i_req_addr, i_req_wdata, i_req_mask : request payload
//   o_rsp_valid/i_rsp_ready: response handshake
//   o_rsp_rdata, o_rsp_err : response payload (rdata is 0 for writes/errors)
//   o_stat_rd_cnt, o_stat_wr_cnt, o_stat_err_cnt : saturating request
//     counters, present only when the RAM_STAT_EN macro is defined.
module ram_banked_sp
  import ram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH_BITS = 12,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE  = ADDR_WIDTH'(32'h8000_0000)
) (
  input  logic                    i_sys_clk,
  input  logic                    i_sys_rst_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_wr,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [DATA_WIDTH-1:0]   i_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_req_mask,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic                    o_rsp_err
`ifdef RAM_STAT_EN
  ,
  output logic [31:0]             o_stat_rd_cnt,
  output logic [31:0]             o_stat_wr_cnt,
  output logic [31:0]             o_stat_err_cnt
`endif
);

  localparam int LANES = lane_cnt(DATA_WIDTH);
  localparam int LB    = lane_bits(DATA_WIDTH);
  localparam int HI    = DEPTH_BITS + LB;

  ram_req_t req;
  ram_rsp_t rsp;

  always_comb begin
    req                        = '0;
    req.wr                     = i_req_wr;
    req.addr[ADDR_WIDTH-1:0]   = i_req_addr;
    req.wdata[DATA_WIDTH-1:0]  = i_req_wdata;
    req.mask[LANES-1:0]        = i_req_mask;
  end

  // ---------------------------------------------------------------- decode
  logic [ADDR_WIDTH-1:0] off;
  logic                  in_range;
  logic [DEPTH_BITS-1:0] idx;

  // Wrapping subtraction: addresses below the base land far above the
  // window and fail the range test.
  assign off = req.addr[ADDR_WIDTH-1:0] - ADDR_BASE;
  assign idx = off[HI-1:LB];

  generate
    if (HI >= ADDR_WIDTH) begin : g_range_full
      assign in_range = 1'b1;
    end else begin : g_range_lim
      assign in_range = ~|off[ADDR_WIDTH-1:HI];
    end
  endgenerate

  // ------------------------------------------------------------- handshake
  logic rsp_valid_q, rsp_valid_d;
  logic rsp_err_q,   rsp_err_d;
  // Set when the held response came from an in-range read, so the lane read
  // registers are the response data; otherwise the data output is forced 0.
  logic rsp_rd_q,    rsp_rd_d;
  logic req_ready;
  logic accept;

  assign req_ready = !rsp_valid_q || i_rsp_ready;
  assign accept    = i_req_valid && req_ready;

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rd_d    = rsp_rd_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = !in_range;
      rsp_rd_d    = in_range && !req.wr;
    end else if (i_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rd_q    <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rd_q    <= rsp_rd_d;
    end
  end

  // ----------------------------------------------------------------- lanes
  logic                  do_access;
  logic [DATA_WIDTH-1:0] lane_rdata;

  // Reset suppresses array access so a request in the reset cycle is dropped.
  assign do_access = i_sys_rst_n && accept && in_range;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      ram_lane #(
        .DEPTH_BITS(DEPTH_BITS)
      ) u_lane (
        .clk_i   (i_sys_clk),
        .we_i    (do_access && req.wr && req.mask[gi]),
        .re_i    (do_access && !req.wr),
        .addr_i  (idx),
        .wdata_i (req.wdata[gi*8 +: 8]),
        .rdata_o (lane_rdata[gi*8 +: 8])
      );
    end
  endgenerate

  // -------------------------------------------------------------- response
  always_comb begin
    rsp                       = '0;
    rsp.rdata[DATA_WIDTH-1:0] = rsp_rd_q ? lane_rdata : '0;
    rsp.err                   = rsp_err_q;
  end

  assign o_req_ready = req_ready;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp.rdata[DATA_WIDTH-1:0];
  assign o_rsp_err   = rsp.err;

  // Bundle bits beyond this configuration's widths and the lane-select bits
  // of the offset are intentionally unused.
  logic unused_bits;
  assign unused_bits = ^{req, rsp, off};

`ifdef RAM_STAT_EN
  // ------------------------------------------------------------ statistics
  logic [31:0] stat_rd_q,  stat_rd_d;
  logic [31:0] stat_wr_q,  stat_wr_d;
  logic [31:0] stat_err_q, stat_err_d;

  always_comb begin
    stat_rd_d  = stat_rd_q;
    stat_wr_d  = stat_wr_q;
    stat_err_d = stat_err_q;
    if (accept) begin
      if (!in_range) begin
        stat_err_d = sat_inc(stat_err_q);
      end else if (req.wr) begin
        stat_wr_d = sat_inc(stat_wr_q);
      end else begin
        stat_rd_d = sat_inc(stat_rd_q);
      end
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      stat_rd_q  <= '0;
      stat_wr_q  <= '0;
      stat_err_q <= '0;
    end else begin
      stat_rd_q  <= stat_rd_d;
      stat_wr_q  <= stat_wr_d;
      stat_err_q <= stat_err_d;
    end
  end

  assign o_stat_rd_cnt  = stat_rd_q;
  assign o_stat_wr_cnt  = stat_wr_q;
  assign o_stat_err_cnt = stat_err_q;
`endif

endmodule

// File: tb/tb_ram_banked_sp.sv
// tb_ram_banked_sp: randomized and directed checks of ram_banked_sp against a
// word-array reference model. With RAM_STAT_EN defined the bench uses a
// 64-bit bus and also checks the request counters.
module tb_ram_banked_sp;

`ifdef RAM_STAT_EN
  localparam int DW = 64;
`else
  localparam int DW = 32;
`endif
  localparam int          AW    = 32;
  localparam int          DB    = 12;
  localparam int          LANES = DW / 8;
  localparam int          WORDS = 1 << DB;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic             req_wr;
  logic [AW-1:0]    req_addr;
  logic [DW-1:0]    req_wdata;
  logic [LANES-1:0] req_mask;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;
`ifdef RAM_STAT_EN
  logic [31:0]      stat_rd, stat_wr, stat_err;
`endif

  always #5 clk = ~clk;

  ram_banked_sp #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH_BITS(DB),
    .ADDR_BASE (BASE)
  ) dut (
    .i_sys_clk   (clk),
    .i_sys_rst_n (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_wr    (req_wr),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .i_req_mask  (req_mask),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err)
`ifdef RAM_STAT_EN
    ,
    .o_stat_rd_cnt  (stat_rd),
    .o_stat_wr_cnt  (stat_wr),
    .o_stat_err_cnt (stat_err)
`endif
  );

  // ------------------------------------------------------- reference model
  logic [DW-1:0] mem_m [WORDS];
  bit            known_m;
  bit            rsp_valid_m;
  logic [DW-1:0] rsp_rdata_m;
  bit            rsp_err_m;
  int unsigned   cnt_rd_m, cnt_wr_m, cnt_err_m;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    logic [31:0] off;
    int          idx;
    if (!rst_n) begin
      rsp_valid_m = 0;
      rsp_rdata_m = '0;
      rsp_err_m   = 0;
      cnt_rd_m    = 0;
      cnt_wr_m    = 0;
      cnt_err_m   = 0;
      known_m     = 1;
    end else if (req_valid && (!rsp_valid_m || rsp_ready)) begin
      off = req_addr - BASE;
      idx = int'(off / LANES);
      rsp_valid_m = 1;
      if (off >= WORDS * LANES) begin
        rsp_rdata_m = '0;
        rsp_err_m   = 1;
        cnt_err_m++;
        $display("txn ERR  addr=%h", req_addr);
      end else if (req_wr) begin
        for (int l = 0; l < LANES; l++)
          if (req_mask[l]) mem_m[idx][l*8 +: 8] = req_wdata[l*8 +: 8];
        rsp_rdata_m = '0;
        rsp_err_m   = 0;
        cnt_wr_m++;
        $display("txn WR   addr=%h data=%h mask=%b", req_addr, req_wdata, req_mask);
      end else begin
        rsp_rdata_m = mem_m[idx];
        rsp_err_m   = 0;
        cnt_rd_m++;
        $display("txn RD   addr=%h exp=%h", req_addr, rsp_rdata_m);
      end
    end else if (rsp_ready) begin
      rsp_valid_m = 0;
    end
  endtask

  // One cycle: inputs were set just after a falling edge.
  task automatic step();
    bit in_reset;
    #1;
    if (known_m) chk("req_ready", 64'(req_ready), 64'(!rsp_valid_m || rsp_ready));
    in_reset = !rst_n;
    @(posedge clk);
    model_edge();
    #1;
    chk("rsp_valid", 64'(rsp_valid), 64'(rsp_valid_m));
    if (rsp_valid_m || in_reset) begin
      chk("rsp_rdata", 64'(rsp_rdata), 64'(rsp_rdata_m));
      chk("rsp_err", 64'(rsp_err), 64'(rsp_err_m));
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input bit wr, input logic [31:0] a,
                       input logic [DW-1:0] d, input logic [LANES-1:0] m, input bit rr);
    req_valid = v;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    req_mask  = m;
    rsp_ready = rr;
    step();
  endtask

  function automatic logic [31:0] waddr(input int idx);
    return BASE + 32'(idx * LANES);
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return DW'({$urandom, $urandom});
  endfunction

  function automatic logic [31:0] oor_addr();
    case ($urandom_range(0, 3))
      0:       return BASE - 32'(LANES);
      1:       return BASE + 32'(WORDS * LANES);
      2:       return 32'h0000_0000;
      default: return 32'hFFFF_FFF0;
    endcase
  endfunction

  localparam logic [LANES-1:0] ALL = '1;

  initial begin
    logic [DW-1:0] held;
    known_m     = 0;
    rsp_valid_m = 0;
    rsp_rdata_m = '0;
    rsp_err_m   = 0;
    for (int i = 0; i < WORDS; i++) mem_m[i] = 'x;
    rst_n = 1'b0;
    @(negedge clk);

    // Reset: response channel idle and zeroed.
    drive(0, 0, BASE, '0, '0, 1);
    drive(0, 0, BASE, '0, '0, 1);
    rst_n = 1'b1;
    drive(0, 0, BASE, '0, '0, 1);

    // Known contents for the window the bench exercises.
    for (int i = 0; i < 64; i++) drive(1, 1, waddr(i), rnd_data(), ALL, 1);

    // Full write then immediate read of the same word.
    drive(1, 1, BASE + 32'h10, DW'(32'hDEAD_BEEF), ALL, 1);
    drive(1, 0, BASE + 32'h10, '0, '0, 1);
    chk("rd_deadbeef", 64'(rsp_rdata), 64'(32'hDEAD_BEEF));

    // Partial-lane write merges with preloaded data.
    drive(1, 1, BASE + 32'h20, DW'(32'h1122_3344), ALL, 1);
    drive(1, 1, BASE + 32'h20, DW'(32'hAABB_CCDD), LANES'(4'b0101), 1);
    drive(1, 0, BASE + 32'h20, '0, '0, 1);
    chk("rd_merge", 64'(rsp_rdata[31:0]), 64'(32'h11BB_33DD));

    // Mask 0 write: response returned, no lane changes.
    drive(1, 1, BASE + 32'h20, rnd_data(), '0, 1);
    drive(1, 0, BASE + 32'h20, '0, '0, 1);

    // Out-of-range just below and just above the window.
    drive(1, 0, BASE - 32'(LANES), '0, '0, 1);
    chk("oor_lo_err", 64'(rsp_err), 64'd1);
    drive(1, 1, BASE + 32'(WORDS * LANES), rnd_data(), ALL, 1);
    chk("oor_hi_err", 64'(rsp_err), 64'd1);
    drive(1, 0, BASE, '0, '0, 1);

    // Stall: response held three cycles, nothing accepted.
    drive(1, 0, BASE + 32'h10, '0, '0, 1);
    held = rsp_rdata;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, BASE + 32'h10, rnd_data(), ALL, 0);
      chk("stall_ready", 64'(req_ready), 64'd0);
      chk("stall_hold", 64'(rsp_rdata), 64'(held));
    end
    for (int i = 0; i < 3; i++) drive(1, 0, waddr(i), '0, '0, 1);
    drive(0, 0, BASE, '0, '0, 1);

    // Reset with a pending response and a write in flight.
    drive(1, 0, BASE + 32'h30, '0, '0, 0);
    rst_n = 1'b0;
    drive(1, 1, BASE + 32'h30, ~mem_m[12], ALL, 0);
    rst_n = 1'b1;
    chk("rst_ready", 64'(req_ready), 64'd1);
    drive(1, 0, BASE + 32'h30, '0, '0, 1);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      bit v, wr, rr;
      logic [31:0] a;
      v  = ($urandom_range(0, 9) < 8);
      wr = $urandom_range(0, 1) == 1;
      rr = ($urandom_range(0, 3) != 0);
      a  = ($urandom_range(0, 9) == 0) ? oor_addr()
         : waddr($urandom_range(0, 63)) + 32'($urandom_range(0, LANES - 1));
      drive(v, wr, a, rnd_data(), LANES'($urandom), rr);
    end
    drive(0, 0, BASE, '0, '0, 1);

`ifdef RAM_STAT_EN
    chk("stat_rd_rand", 64'(stat_rd), 64'(cnt_rd_m));
    chk("stat_wr_rand", 64'(stat_wr), 64'(cnt_wr_m));
    chk("stat_err_rand", 64'(stat_err), 64'(cnt_err_m));
    rst_n = 1'b0;
    drive(0, 0, BASE, '0, '0, 1);
    rst_n = 1'b1;
    chk("stat_rd_rst", 64'(stat_rd), 64'd0);
    for (int i = 0; i < 5; i++) drive(1, 0, waddr(i), '0, '0, 1);
    drive(1, 1, waddr(1), 64'h0102_0304_0506_0708, 8'hA5, 1);
    drive(1, 1, waddr(2), rnd_data(), 8'h80, 1);
    drive(1, 1, waddr(3), rnd_data(), 8'h01, 1);
    drive(1, 0, oor_addr(), '0, '0, 1);
    drive(1, 1, BASE + 32'(WORDS * LANES), rnd_data(), ALL, 1);
    drive(0, 0, BASE, '0, '0, 1);
    chk("stat_rd", 64'(stat_rd), 64'd5);
    chk("stat_wr", 64'(stat_wr), 64'd3);
    chk("stat_err", 64'(stat_err), 64'd2);
    // Lane masks on the wide bus: stats reads are not counted here.
    for (int i = 1; i < 4; i++) drive(1, 0, waddr(i), '0, '0, 1);
    drive(0, 0, BASE, '0, '0, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Bound the run in case the clocked sequence ever stalls.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_banked_sp.md
Name: ram_banked_sp

Overview:
- Parametrised, byte-lane-banked, single-port data RAM for the core's load/store path.
- Successor to the fixed 32-bit combinational-read RAM: generic width/depth/base, registered (synchronous) read, valid/ready request and response channels with backpressure, out-of-range error flag.
- Sits between the LSU and the memory map. One request per cycle; fixed 1-cycle latency when the response is not stalled.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; multiple of 8, minimum 8.
- ADDR_WIDTH, 32, byte-address width.
- DEPTH_BITS, 12, log2 of the number of words per bank.
- ADDR_BASE, 32'h8000_0000, byte address of word 0.

Ports:
- i_sys_clk  in  1  clock
- i_sys_rst_n  in  1  reset: synchronous, active-low
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request accepted when valid&&ready
- i_req_wr  in  1  1 = write, 0 = read
- i_req_addr  in  ADDR_WIDTH  byte address; lane bits ignored
- i_req_wdata  in  DATA_WIDTH  write data
- i_req_mask  in  DATA_WIDTH/8  byte-lane write enables
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response consumed when valid&&ready
- o_rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- o_rsp_err  out  1  address out of range

Behaviour:
- LANES = DATA_WIDTH/8; LB = log2(LANES).
- off = i_req_addr - ADDR_BASE, computed at ADDR_WIDTH and wrapping on subtraction.
- In range iff off < (2**DEPTH_BITS)*LANES. idx = off[DEPTH_BITS+LB-1:LB].
- o_req_ready = !o_rsp_valid || i_rsp_ready. This is combinational on i_rsp_ready; there is no path from i_req_valid.
- Accept at edge N:
  - Write, in range: lanes with mask=1 are written at edge N; others are unchanged.
  - Read, in range: all lanes at idx are registered into o_rsp_rdata at edge N.
  - Out of range: no array access; o_rsp_err=1, o_rsp_rdata=0.
  - o_rsp_valid=1 after edge N, i.e. latency 1.
- Write response: o_rsp_rdata=0, o_rsp_err=0 when in range.
- Write with mask=0 is legal: no lane changes; a response is still returned.
- Stall: while o_rsp_valid && !i_rsp_ready, o_rsp_rdata and o_rsp_err hold stable and no request is accepted.
- Response consumed with no new accept: o_rsp_valid clears on the next edge.
- Consume and accept in the same cycle: back-to-back; o_rsp_valid stays 1 with the new data.
- Write at N followed by a read of the same idx accepted at N+1 returns the new data. No forwarding logic is needed.
- Reset (i_sys_rst_n=0 at an edge): o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0.
  - Any pending response is dropped.
  - A request presented in the reset cycle is not executed: no array write.
  - Array contents are not reset.
- o_req_ready is 1 after reset.

Optional Feature:
- Macro RAM_STAT_EN. When defined, three outputs are added: o_stat_rd_cnt, o_stat_wr_cnt, o_stat_err_cnt, 32 bits each.
  - Counts are of accepted in-range reads, accepted in-range writes, and accepted out-of-range requests respectively.
  - Counters saturate at 32'hFFFF_FFFF and are cleared by reset.
- When not defined, the ports and counter logic do not exist; all other behaviour is identical.

Decomposition:
- Package ram_pkg holds:
  - lane_cnt/lane_bits constant functions;
  - typedef ram_req_t {wr, addr, wdata, mask};
  - typedef ram_rsp_t {rdata, err};
  - the saturating-increment function for the stat counters.
- Sub-module ram_lane: one 8-bit x 2**DEPTH_BITS array with synchronous write enable and synchronous read enable, registered read data. Instantiated LANES times in a generate loop.
- The top level owns decode, handshake and the response register.

Test Plan:
- Write 0xDEADBEEF to 0x8000_0010, mask 4'hF, then read 0x8000_0010 on the next cycle -> read response at +1 cycle with rdata 0xDEADBEEF, err=0.
- Preload 0x11223344 at 0x8000_0020, write 0xAABBCCDD with mask 4'b0101, then read -> 0x11BB33DD.
- Read 0x7FFF_FFFC, then read 0x8000_4000 (DEPTH_BITS=12) -> both return err=1, rdata=0; array unchanged.
- Hold i_rsp_ready=0 for 3 cycles with i_req_valid=1 -> o_req_ready=0 and response stable for all 3 cycles; after i_rsp_ready=1, back-to-back responses arrive 1 per cycle.
- Assert reset with o_rsp_valid=1 and a write request present -> next cycle o_rsp_valid=0, rdata=0, err=0; a read of that address shows the write did not occur.
- With RAM_STAT_EN and DATA_WIDTH=64: 5 reads, 3 writes, 2 out-of-range requests -> counters read 5/3/2; 8-lane masks are honoured.
